// File: rtl/sys_ctrl_pkg.sv
// Shared SYS_CTRL types and default timing constants for the per-domain power sequencers.
package sys_ctrl_pkg;

    typedef enum logic [2:0] {
        SEQ_OFF       = 3'd0,
        SEQ_PLL_CFG   = 3'd1,
        SEQ_LOCK_WAIT = 3'd2,
        SEQ_CLK_ON    = 3'd3,
        SEQ_RUN       = 3'd4,
        SEQ_RST_HOLD  = 3'd5,
        SEQ_ERROR     = 3'd6
    } seq_state_e;

    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 4096;
    localparam int unsigned DEF_RST_DELAY_CYCLES    = 8;

endpackage

// File: rtl/core_pwr_seq.sv
// Per-domain power sequencer: PLL load, lock qualification, clock ungate, delayed reset release,
// and the reverse teardown. All outputs are registered from the next-state decode.
module core_pwr_seq
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned RST_DELAY_CYCLES    = DEF_RST_DELAY_CYCLES
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic        clk_en_req_i,
    input  logic        rst_n_req_i,
    input  logic [3:0]  pll_ref_div_i,
    input  logic [11:0] pll_fb_div_i,
    input  logic        pll_locked_i,
    output logic [3:0]  pll_ref_div_o,
    output logic [11:0] pll_fb_div_o,
    output logic        pll_cfg_load_o,
    output logic        clk_gate_en_o,
    output logic        core_rst_no,
    output logic        busy_o,
    output logic        timeout_err_o,
    output logic [2:0]  seq_state_o
);

    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(RST_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_SAT    = CNT_W'(RST_DELAY_CYCLES);
    localparam logic [STB_W-1:0] STABLE_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STB_W-1:0] stb_q, stb_d;
    logic             err_q, err_d;
    logic [3:0]       ref_q;
    logic [11:0]      fb_q;
    logic             load_q, gate_q, rst_n_q, busy_q;

    logic stable_hit, timeout_hit, delay_done, div_changed;

    // The "last" comparisons fire on the edge that completes the count, so the
    // new state is visible exactly LOCK_STABLE / LOCK_TIMEOUT / RST_DELAY edges after entry.
    assign stable_hit  = pll_locked_i && (stb_q == STABLE_LAST);
    assign timeout_hit = (cnt_q == TIMEOUT_LAST);
    assign delay_done  = (cnt_q >= DELAY_LAST);
    assign div_changed = (pll_ref_div_i != ref_q) || (pll_fb_div_i != fb_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        stb_d   = '0;
        err_d   = err_q;
        case (state_q)
            SEQ_OFF: begin
                if (clk_en_req_i) state_d = SEQ_PLL_CFG;
            end
            SEQ_PLL_CFG: begin
                state_d = SEQ_LOCK_WAIT;
            end
            SEQ_LOCK_WAIT: begin
                if (!clk_en_req_i) begin
                    state_d = SEQ_OFF;
                end else if (stable_hit) begin
                    state_d = SEQ_CLK_ON;
                end else if (timeout_hit) begin
                    state_d = SEQ_ERROR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    stb_d = pll_locked_i ? stb_q + 1'b1 : '0;
                end
            end
            SEQ_CLK_ON: begin
                if (!clk_en_req_i) begin
                    state_d = SEQ_RST_HOLD;
                end else if (delay_done && rst_n_req_i) begin
                    state_d = SEQ_RUN;
                end else begin
                    cnt_d = delay_done ? DELAY_SAT : cnt_q + 1'b1;
                end
            end
            SEQ_RUN: begin
                if (!clk_en_req_i || !pll_locked_i || div_changed) begin
                    state_d = SEQ_RST_HOLD;
                end else if (!rst_n_req_i) begin
                    state_d = SEQ_CLK_ON;
                end
            end
            SEQ_RST_HOLD: begin
                if (delay_done) state_d = SEQ_OFF;
                else            cnt_d   = cnt_q + 1'b1;
            end
            SEQ_ERROR: begin
                if (!clk_en_req_i) state_d = SEQ_OFF;
            end
            default: begin
                state_d = SEQ_OFF;
            end
        endcase
        if (state_d == SEQ_PLL_CFG) err_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= SEQ_OFF;
            cnt_q   <= '0;
            stb_q   <= '0;
            err_q   <= 1'b0;
            ref_q   <= '0;
            fb_q    <= '0;
            load_q  <= 1'b0;
            gate_q  <= 1'b0;
            rst_n_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
            load_q  <= (state_d == SEQ_PLL_CFG);
            gate_q  <= (state_d inside {SEQ_CLK_ON, SEQ_RUN, SEQ_RST_HOLD});
            rst_n_q <= (state_d == SEQ_RUN);
            busy_q  <= (state_d inside {SEQ_PLL_CFG, SEQ_LOCK_WAIT, SEQ_CLK_ON, SEQ_RST_HOLD});
            if (state_d == SEQ_PLL_CFG) begin
                ref_q <= pll_ref_div_i;
                fb_q  <= pll_fb_div_i;
            end
        end
    end

    assign pll_ref_div_o  = ref_q;
    assign pll_fb_div_o   = fb_q;
    assign pll_cfg_load_o = load_q;
    assign clk_gate_en_o  = gate_q;
    assign core_rst_no    = rst_n_q;
    assign busy_o         = busy_q;
    assign timeout_err_o  = err_q;
    assign seq_state_o    = state_q;

endmodule

// File: tb/tb_core_pwr_seq.sv
// Directed bench for core_pwr_seq: power-up, reset re-request, divider change, lock loss,
// lock glitch, synchronous reset, lock timeout and the stable/timeout tie.
module tb_core_pwr_seq;
    import sys_ctrl_pkg::*;

    logic        clk;
    logic        srst;
    logic        clk_en_req;
    logic        rst_n_req;
    logic [3:0]  ref_div;
    logic [11:0] fb_div;
    logic        pll_locked;
    logic [3:0]  pll_ref_div_o;
    logic [11:0] pll_fb_div_o;
    logic        pll_cfg_load_o;
    logic        clk_gate_en_o;
    logic        core_rst_no;
    logic        busy_o;
    logic        timeout_err_o;
    logic [2:0]  seq_state_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [11:0] exp_q[$];

    core_pwr_seq #(
        .LOCK_STABLE_CYCLES  (16),
        .LOCK_TIMEOUT_CYCLES (64),
        .RST_DELAY_CYCLES    (8)
    ) dut (
        .clk_i          (clk),
        .srst_i         (srst),
        .clk_en_req_i   (clk_en_req),
        .rst_n_req_i    (rst_n_req),
        .pll_ref_div_i  (ref_div),
        .pll_fb_div_i   (fb_div),
        .pll_locked_i   (pll_locked),
        .pll_ref_div_o  (pll_ref_div_o),
        .pll_fb_div_o   (pll_fb_div_o),
        .pll_cfg_load_o (pll_cfg_load_o),
        .clk_gate_en_o  (clk_gate_en_o),
        .core_rst_no    (core_rst_no),
        .busy_o         (busy_o),
        .timeout_err_o  (timeout_err_o),
        .seq_state_o    (seq_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input seq_state_e st, input logic gate,
                            input logic rstn, input logic busy);
        check({tag, ".state"}, 32'(seq_state_o), 32'(st));
        check({tag, ".gate"}, 32'(clk_gate_en_o), 32'(gate));
        check({tag, ".rstn"}, 32'(core_rst_no), 32'(rstn));
        check({tag, ".busy"}, 32'(busy_o), 32'(busy));
    endtask

    // driver: advance n edges, then settle 1ns past the edge
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // scoreboard: every load pulse must present the next expected feedback divider
    always @(negedge clk) begin
        if (pll_cfg_load_o === 1'b1) begin
            if (exp_q.size() == 0) check("load_unexpected", 32'(pll_cfg_load_o), 32'd0);
            else                   check("load_fb", 32'(pll_fb_div_o), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        srst       = 1'b1;
        clk_en_req = 1'b0;
        rst_n_req  = 1'b0;
        ref_div    = 4'h2;
        fb_div     = 12'h050;
        pll_locked = 1'b0;
        tick_n(3);
        chk_outs("rst", SEQ_OFF, 1'b0, 1'b0, 1'b0);
        check("rst.load", 32'(pll_cfg_load_o), 32'd0);
        check("rst.err", 32'(timeout_err_o), 32'd0);
        check("rst.fb", 32'(pll_fb_div_o), 32'd0);

        // power-up, cycle 0
        srst       = 1'b0;
        clk_en_req = 1'b1;
        rst_n_req  = 1'b1;
        pll_locked = 1'b1;
        exp_q.push_back(12'h050);
        tick_n(1);
        chk_outs("pu1", SEQ_PLL_CFG, 1'b0, 1'b0, 1'b1);
        check("pu1.load", 32'(pll_cfg_load_o), 32'd1);
        check("pu1.ref", 32'(pll_ref_div_o), 32'h2);
        tick_n(1);
        chk_outs("pu2", SEQ_LOCK_WAIT, 1'b0, 1'b0, 1'b1);
        check("pu2.load", 32'(pll_cfg_load_o), 32'd0);
        tick_n(15);
        chk_outs("pu17", SEQ_LOCK_WAIT, 1'b0, 1'b0, 1'b1);
        tick_n(1);
        chk_outs("pu18", SEQ_CLK_ON, 1'b1, 1'b0, 1'b1);
        tick_n(7);
        chk_outs("pu25", SEQ_CLK_ON, 1'b1, 1'b0, 1'b1);
        tick_n(1);
        chk_outs("pu26", SEQ_RUN, 1'b1, 1'b1, 1'b0);
        tick_n(3);

        // reset re-request in RUN
        rst_n_req = 1'b0;
        tick_n(1);
        chk_outs("rr0", SEQ_CLK_ON, 1'b1, 1'b0, 1'b1);
        rst_n_req = 1'b1;
        tick_n(7);
        chk_outs("rr7", SEQ_CLK_ON, 1'b1, 1'b0, 1'b1);
        tick_n(1);
        chk_outs("rr8", SEQ_RUN, 1'b1, 1'b1, 1'b0);

        // divider change in RUN
        fb_div = 12'h064;
        exp_q.push_back(12'h064);
        tick_n(1);
        chk_outs("fb0", SEQ_RST_HOLD, 1'b1, 1'b0, 1'b1);
        tick_n(7);
        chk_outs("fb7", SEQ_RST_HOLD, 1'b1, 1'b0, 1'b1);
        tick_n(1);
        chk_outs("fb8", SEQ_OFF, 1'b0, 1'b0, 1'b0);
        tick_n(1);
        chk_outs("fb9", SEQ_PLL_CFG, 1'b0, 1'b0, 1'b1);
        check("fb9.load", 32'(pll_cfg_load_o), 32'd1);
        check("fb9.fbdiv", 32'(pll_fb_div_o), 32'h064);
        tick_n(25);
        chk_outs("fb34", SEQ_RUN, 1'b1, 1'b1, 1'b0);

        // lock loss in RUN, recovery with a one-sample glitch at LOCK_WAIT cycle 10
        pll_locked = 1'b0;
        exp_q.push_back(12'h064);
        tick_n(1);
        chk_outs("ll0", SEQ_RST_HOLD, 1'b1, 1'b0, 1'b1);
        tick_n(8);
        chk_outs("ll8", SEQ_OFF, 1'b0, 1'b0, 1'b0);
        pll_locked = 1'b1;
        tick_n(1);
        chk_outs("ll9", SEQ_PLL_CFG, 1'b0, 1'b0, 1'b1);
        tick_n(1);
        chk_outs("gl0", SEQ_LOCK_WAIT, 1'b0, 1'b0, 1'b1);
        tick_n(10);
        pll_locked = 1'b0;
        tick_n(1);
        pll_locked = 1'b1;
        tick_n(5);
        chk_outs("gl16", SEQ_LOCK_WAIT, 1'b0, 1'b0, 1'b1);
        tick_n(10);
        chk_outs("gl26", SEQ_LOCK_WAIT, 1'b0, 1'b0, 1'b1);
        tick_n(1);
        chk_outs("gl27", SEQ_CLK_ON, 1'b1, 1'b0, 1'b1);
        check("gl27.err", 32'(timeout_err_o), 32'd0);

        // synchronous reset mid-sequence
        srst = 1'b1;
        tick_n(1);
        chk_outs("sr", SEQ_OFF, 1'b0, 1'b0, 1'b0);
        check("sr.load", 32'(pll_cfg_load_o), 32'd0);
        check("sr.fb", 32'(pll_fb_div_o), 32'd0);
        check("sr.ref", 32'(pll_ref_div_o), 32'd0);
        srst = 1'b0;
        exp_q.push_back(12'h064);
        tick_n(1);
        chk_outs("sr1", SEQ_PLL_CFG, 1'b0, 1'b0, 1'b1);
        check("sr1.load", 32'(pll_cfg_load_o), 32'd1);

        // lock never asserts: timeout after 64 LOCK_WAIT cycles
        pll_locked = 1'b0;
        tick_n(1);
        chk_outs("to0", SEQ_LOCK_WAIT, 1'b0, 1'b0, 1'b1);
        tick_n(63);
        chk_outs("to63", SEQ_LOCK_WAIT, 1'b0, 1'b0, 1'b1);
        check("to63.err", 32'(timeout_err_o), 32'd0);
        tick_n(1);
        chk_outs("to64", SEQ_ERROR, 1'b0, 1'b0, 1'b0);
        check("to64.err", 32'(timeout_err_o), 32'd1);
        tick_n(3);
        chk_outs("to67", SEQ_ERROR, 1'b0, 1'b0, 1'b0);
        clk_en_req = 1'b0;
        tick_n(1);
        chk_outs("to_off", SEQ_OFF, 1'b0, 1'b0, 1'b0);
        check("to_off.err", 32'(timeout_err_o), 32'd1);
        clk_en_req = 1'b1;
        exp_q.push_back(12'h064);
        tick_n(1);
        chk_outs("to_cfg", SEQ_PLL_CFG, 1'b0, 1'b0, 1'b1);
        check("to_cfg.err", 32'(timeout_err_o), 32'd0);

        // stable count and timeout complete on the same edge
        tick_n(1);
        tick_n(48);
        pll_locked = 1'b1;
        tick_n(15);
        chk_outs("tie63", SEQ_LOCK_WAIT, 1'b0, 1'b0, 1'b1);
        tick_n(1);
        chk_outs("tie64", SEQ_CLK_ON, 1'b1, 1'b0, 1'b1);
        check("tie64.err", 32'(timeout_err_o), 32'd0);

        // enable withdrawn in CLK_ON, then in LOCK_WAIT
        clk_en_req = 1'b0;
        tick_n(1);
        chk_outs("ce_clk", SEQ_RST_HOLD, 1'b1, 1'b0, 1'b1);
        tick_n(8);
        chk_outs("ce_off", SEQ_OFF, 1'b0, 1'b0, 1'b0);
        clk_en_req = 1'b1;
        exp_q.push_back(12'h064);
        tick_n(2);
        chk_outs("ce_lw", SEQ_LOCK_WAIT, 1'b0, 1'b0, 1'b1);
        clk_en_req = 1'b0;
        tick_n(1);
        chk_outs("ce_lw_off", SEQ_OFF, 1'b0, 1'b0, 1'b0);

        tick_n(3);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
